apb_master: RTL and testbench

APB requester (initiator) for the timer IP subsystem. It accepts single read or write commands from a local host-side request port and runs each one as a standard APB SETUP/ACCESS transfer, inserting wait states until pready. It returns read data and an error status on a one-cycle response strobe. A programmable timeout aborts transfers whose completer never raises pready.

---
 rtl/apb_master.sv | 152 +++++++++++++++
 tb/tb_apb_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: runs single host read/write commands as APB SETUP/ACCESS
// transfers, with wait-state insertion and an optional ACCESS-phase timeout.
module apb_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    // Response fields hold between completions; only rsp_valid is a strobe.
    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;

        unique case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                // pready wins over a timeout expiring on the same edge.
                if (pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                end else if (TO_EN && (wait_cnt_q == CNT_LAST)) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    assign cmd_ready   = (state_q == IDLE);
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: transfer timing, wait states, errors,
// timeout abort, back-to-back commands and mid-transfer reset.
module tb_apb_master;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int tests_run    = 0;
    int tests_failed = 0;

    int            obs_lat, obs_psel, obs_pen;
    logic          obs_got_rsp, obs_stable, obs_rsp_after, obs_ready_at_rsp, obs_hold;
    logic [DW-1:0] obs_rdata;
    logic          obs_err, obs_to;

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    // Issues one command from IDLE and plays a completer that raises pready
    // after 'waits' low ACCESS cycles; records what the bus and response did.
    task automatic run_transfer(input logic w, input logic [AW-1:0] a,
                                input logic [DW-1:0] wd, input int waits,
                                input logic [DW-1:0] rd, input logic se,
                                input int max_cycles);
        int acc_cycles;
        acc_cycles = 0;
        obs_lat = 0; obs_psel = 0; obs_pen = 0;
        obs_got_rsp = 0; obs_stable = 1; obs_rsp_after = 1'bx;
        obs_ready_at_rsp = 0; obs_hold = 0;
        obs_rdata = 'x; obs_err = 1'bx; obs_to = 1'bx;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
        pready = 0; pslverr = 0; prdata = '0;
        for (int c = 1; c <= max_cycles && !obs_got_rsp; c++) begin
            @(posedge clk); #1;
            cmd_valid = 0;
            if (psel) begin
                obs_psel++;
                if (paddr !== a || pwrite !== w || pwdata !== wd) obs_stable = 0;
            end
            if (penable) begin
                obs_pen++;
                acc_cycles++;
            end
            if (rsp_valid) begin
                obs_got_rsp      = 1;
                obs_lat          = c;
                obs_rdata        = rsp_rdata;
                obs_err          = rsp_err;
                obs_to           = rsp_timeout;
                obs_ready_at_rsp = cmd_ready;
            end
            if (penable && acc_cycles > waits) begin
                pready = 1; prdata = rd; pslverr = se;
            end else begin
                pready = 0; prdata = '0; pslverr = 0;
            end
        end
        pready = 0; prdata = '0; pslverr = 0;
        if (obs_got_rsp) begin
            @(posedge clk); #1;
            obs_rsp_after = rsp_valid;
            obs_hold = (paddr === a) && (pwrite === w) && (psel === 0) && (penable === 0);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        prdata = '0; pready = 0; pslverr = 0;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        tests_run++;
        if ({psel, penable, pwrite} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_apb_ctrl got %b want 000", {psel, penable, pwrite}); end
        tests_run++;
        if (paddr !== '0 || pwdata !== '0) begin tests_failed++; $display("[TB] FAIL reset_apb_data got %h/%h want 0/0", paddr, pwdata); end
        tests_run++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000 || rsp_rdata !== '0) begin
            tests_failed++; $display("[TB] FAIL reset_rsp got %b rdata %h want 000 rdata 0", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_zero_wait();
        run_transfer(1'b1, 12'h004, 32'hA5A5_0001, 0, 32'hDEAD_BEEF, 1'b0, 20);
        tests_run++;
        if (obs_got_rsp !== 1'b1) begin tests_failed++; $display("[TB] FAIL wr_rsp_seen got %b want 1", obs_got_rsp); end
        tests_run++;
        if (obs_psel != 2 || obs_pen != 1) begin tests_failed++; $display("[TB] FAIL wr_phase_len psel %0d penable %0d want 2/1", obs_psel, obs_pen); end
        tests_run++;
        if (obs_lat != 3) begin tests_failed++; $display("[TB] FAIL wr_latency got %0d want 3", obs_lat); end
        tests_run++;
        if (obs_stable !== 1'b1) begin tests_failed++; $display("[TB] FAIL wr_bus_stable got %b want 1", obs_stable); end
        tests_run++;
        if (obs_err !== 1'b0 || obs_to !== 1'b0 || obs_rdata !== 32'h0) begin
            tests_failed++; $display("[TB] FAIL wr_rsp err %b to %b rdata %h want 0 0 00000000", obs_err, obs_to, obs_rdata);
        end
        tests_run++;
        if (obs_ready_at_rsp !== 1'b1) begin tests_failed++; $display("[TB] FAIL wr_ready_at_rsp got %b want 1", obs_ready_at_rsp); end
        tests_run++;
        if (obs_rsp_after !== 1'b0) begin tests_failed++; $display("[TB] FAIL wr_rsp_one_cycle got %b want 0", obs_rsp_after); end
        tests_run++;
        if (obs_hold !== 1'b1) begin tests_failed++; $display("[TB] FAIL wr_addr_hold paddr %h psel %b want 004 0", paddr, psel); end
    endtask

    task automatic test_read_wait();
        run_transfer(1'b0, 12'h010, 32'h0, 2, 32'h1234_5678, 1'b0, 20);
        tests_run++;
        if (obs_pen != 3 || obs_psel != 4) begin tests_failed++; $display("[TB] FAIL rd_phase_len psel %0d penable %0d want 4/3", obs_psel, obs_pen); end
        tests_run++;
        if (obs_lat != 5) begin tests_failed++; $display("[TB] FAIL rd_latency got %0d want 5", obs_lat); end
        tests_run++;
        if (obs_rdata !== 32'h1234_5678 || obs_err !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL rd_rsp rdata %h err %b want 12345678 0", obs_rdata, obs_err);
        end
        tests_run++;
        if (rsp_rdata !== 32'h1234_5678) begin tests_failed++; $display("[TB] FAIL rd_rdata_hold got %h want 12345678", rsp_rdata); end
        tests_run++;
        if (obs_stable !== 1'b1) begin tests_failed++; $display("[TB] FAIL rd_bus_stable got %b want 1", obs_stable); end
    endtask

    task automatic test_slverr();
        run_transfer(1'b1, 12'h020, 32'hCAFE_0002, 1, 32'h5555_5555, 1'b1, 20);
        tests_run++;
        if (obs_err !== 1'b1 || obs_to !== 1'b0) begin tests_failed++; $display("[TB] FAIL slverr_rsp err %b to %b want 1 0", obs_err, obs_to); end
        tests_run++;
        if (obs_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL slverr_rdata got %h want 00000000", obs_rdata); end
        tests_run++;
        if (obs_ready_at_rsp !== 1'b1) begin tests_failed++; $display("[TB] FAIL slverr_ready_at_rsp got %b want 1", obs_ready_at_rsp); end
    endtask

    task automatic test_timeout();
        run_transfer(1'b0, 12'h030, 32'h0, 1000, 32'h9999_9999, 1'b0, 30);
        tests_run++;
        if (obs_got_rsp !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_rsp_seen got %b want 1", obs_got_rsp); end
        tests_run++;
        if (obs_pen != 4 || obs_psel != 5) begin tests_failed++; $display("[TB] FAIL to_phase_len psel %0d penable %0d want 5/4", obs_psel, obs_pen); end
        tests_run++;
        if (obs_lat != 6) begin tests_failed++; $display("[TB] FAIL to_latency got %0d want 6", obs_lat); end
        tests_run++;
        if (obs_err !== 1'b1 || obs_to !== 1'b1 || obs_rdata !== 32'h0) begin
            tests_failed++; $display("[TB] FAIL to_rsp err %b to %b rdata %h want 1 1 00000000", obs_err, obs_to, obs_rdata);
        end
        tests_run++;
        if (obs_hold !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_psel_drop psel %b penable %b want 0 0", psel, penable); end
    endtask

    task automatic test_ready_at_timeout_edge();
        run_transfer(1'b0, 12'h034, 32'h0, TO - 1, 32'h0BAD_F00D, 1'b0, 30);
        tests_run++;
        if (obs_pen != 4 || obs_lat != 6) begin tests_failed++; $display("[TB] FAIL edge_len penable %0d lat %0d want 4/6", obs_pen, obs_lat); end
        tests_run++;
        if (obs_to !== 1'b0 || obs_err !== 1'b0 || obs_rdata !== 32'h0BAD_F00D) begin
            tests_failed++; $display("[TB] FAIL edge_rsp to %b err %b rdata %h want 0 0 0badf00d", obs_to, obs_err, obs_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [3];
        logic [AW-1:0] seen  [$];
        int   idx, rsp_cnt, ready_busy, last_rsp;
        logic acc;
        addrs[0] = 12'h100; addrs[1] = 12'h104; addrs[2] = 12'h108;
        idx = 0; rsp_cnt = 0; ready_busy = 0; last_rsp = 0;
        pready = 1; pslverr = 0; prdata = '0;
        cmd_valid = 1; cmd_write = 1; cmd_addr = addrs[0]; cmd_wdata = 32'h1000_0000;
        for (int c = 1; c <= 20 && rsp_cnt < 3; c++) begin
            acc = cmd_valid && cmd_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    cmd_addr  = addrs[idx];
                    cmd_wdata = 32'h1000_0000 + 32'(idx);
                end else begin
                    cmd_valid = 0;
                end
            end
            if (psel && !penable) seen.push_back(paddr);
            if (psel && cmd_ready) ready_busy++;
            if (rsp_valid) begin
                rsp_cnt++;
                last_rsp = c;
            end
        end
        pready = 0; cmd_valid = 0;
        tests_run++;
        if (rsp_cnt != 3 || last_rsp != 9) begin tests_failed++; $display("[TB] FAIL b2b_rsp count %0d last %0d want 3/9", rsp_cnt, last_rsp); end
        tests_run++;
        if (seen.size() != 3) begin
            tests_failed++; $display("[TB] FAIL b2b_setups got %0d want 3", seen.size());
        end else if (seen[0] !== addrs[0] || seen[1] !== addrs[1] || seen[2] !== addrs[2]) begin
            tests_failed++; $display("[TB] FAIL b2b_order got %h %h %h want 100 104 108", seen[0], seen[1], seen[2]);
        end
        tests_run++;
        if (ready_busy != 0) begin tests_failed++; $display("[TB] FAIL b2b_ready_busy got %0d want 0", ready_busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access();
        int rsp_cnt;
        rsp_cnt = 0;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 12'h040; cmd_wdata = '0; pready = 0;
        @(posedge clk); #1;
        cmd_valid = 0;
        repeat (2) begin @(posedge clk); #1; end
        tests_run++;
        if (penable !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_pre_access penable %b want 1", penable); end
        #2 rst_n = 0;
        #1;
        tests_run++;
        if (psel !== 1'b0 || penable !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL rst_async psel %b penable %b ready %b want 0 0 1", psel, penable, cmd_ready);
        end
        @(posedge clk); #1 rst_n = 1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) rsp_cnt++;
        end
        tests_run++;
        if (rsp_cnt != 0) begin tests_failed++; $display("[TB] FAIL rst_no_rsp got %0d want 0", rsp_cnt); end
        run_transfer(1'b0, 12'h044, 32'h0, 1, 32'h7777_0044, 1'b0, 20);
        tests_run++;
        if (obs_got_rsp !== 1'b1 || obs_rdata !== 32'h7777_0044 || obs_lat != 4) begin
            tests_failed++; $display("[TB] FAIL rst_recover seen %b rdata %h lat %0d want 1 77770044 4", obs_got_rsp, obs_rdata, obs_lat);
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_ready_at_timeout_edge();
        test_back_to_back();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
